// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: state encoding, sizing helpers
// and the parameter legality check used at elaboration.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned iter_count(input int unsigned width,
                                               input int unsigned bpc);
        return width / bpc;
    endfunction

    // Counter needs at least one bit even when a single iteration suffices.
    function automatic int unsigned cnt_width(input int unsigned iter);
        return (iter > 1) ? clog2(iter) : 1;
    endfunction

    function automatic bit cfg_legal(input int unsigned width,
                                     input int unsigned bpc);
        bit bpc_ok;
        bpc_ok = (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8);
        return (width >= 2) && bpc_ok && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One partial-product step: adds the pre-shifted multiplicand times one
// multiplier chunk into the running accumulator.
module mult_pp_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [2*WIDTH-1:0]        mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] chunk_i,
    output logic [2*WIDTH-1:0]        acc_o
);

    localparam int unsigned P_W = 2 * WIDTH;

    // Truncation to P_W is safe: the final product always fits in 2*WIDTH bits.
    always_comb begin
        acc_o = acc_i + P_W'(mcand_i * P_W'(chunk_i));
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier retiring BITS_PER_CYCLE multiplier bits
// per cycle, with valid/ready handshakes on operands and product.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned ITER  = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = cnt_width(ITER);
    localparam int unsigned P_W   = 2 * WIDTH;

    if (!cfg_legal(WIDTH, BITS_PER_CYCLE)) begin : g_cfg_check
        $error("seq_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    state_e             state_q, state_d;
    logic [P_W-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [P_W-1:0]     p_q, p_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [P_W-1:0]     acc_step;
    logic               accept;
    logic               last_iter;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sm);
        return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    assign accept    = in_valid & in_ready_q;
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    mult_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .chunk_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_o   (acc_step)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; handshake flags follow the next state.
    always_comb begin
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        p_d         = p_q;
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mcand_d  = P_W'(magnitude(a, signed_mode));
                    mplier_d = magnitude(b, signed_mode);
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    p_d = neg_q ? (~acc_step + P_W'(1)) : acc_step;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: default 32-bit/1-bit-per-cycle instance
// plus a 16-bit/4-bits-per-cycle instance, checked against a plain-arithmetic model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iv32 = 1'b0;
    logic        iv16 = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        sm_in = 1'b0;
    logic        out_rdy = 1'b0;

    logic        rdy32, ov32, busy32;
    logic [63:0] p32;
    logic        rdy16, ov16, busy16;
    logic [31:0] p16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32),
        .a(a_in), .b(b_in), .signed_mode(sm_in), .out_valid(ov32),
        .out_ready(out_rdy), .p(p32), .busy(busy32)
    );

    seq_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(rdy16),
        .a(a_in[15:0]), .b(b_in[15:0]), .signed_mode(sm_in), .out_valid(ov16),
        .out_ready(out_rdy), .p(p16), .busy(busy16)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [63:0] exp_p;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Product of w-bit operands, taken mod 2^(2w) after sign/zero extension.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sm, input int w);
        logic [63:0] amask, pmask, ea, eb;
        amask = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        pmask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        ea = {32'b0, a} & amask;
        eb = {32'b0, b} & amask;
        if (sm && ea[w-1]) ea = ea | ~amask;
        if (sm && eb[w-1]) eb = eb | ~amask;
        return (ea * eb) & pmask;
    endfunction

    function automatic logic rdy(input int w);
        return (w != 0) ? rdy16 : rdy32;
    endfunction

    function automatic logic ov(input int w);
        return (w != 0) ? ov16 : ov32;
    endfunction

    function automatic logic [63:0] pv(input int w);
        return (w != 0) ? {32'b0, p16} : p32;
    endfunction

    task automatic set_iv(input int w, input logic v);
        if (w != 0) iv16 = v;
        else        iv32 = v;
    endtask

    // Full transaction; operands and mode are scrambled right after acceptance.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input logic [63:0] exp_p, input string name);
        int iter;
        int lat;
        iter = (w != 0) ? 4 : 32;
        check({name, " in_ready"}, 64'(rdy(w)), 64'd1);
        a_in = a; b_in = b; sm_in = sm;
        set_iv(w, 1'b1);
        @(negedge clk);
        set_iv(w, 1'b0);
        a_in = $urandom; b_in = $urandom; sm_in = ~sm;
        lat = 0;
        while (!ov(w) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(iter));
        check({name, " p"}, pv(w), exp_p);
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        check({name, " in_ready after"}, 64'(rdy(w)), 64'd1);
    endtask

    initial begin
        vec_t vecs[8];
        logic [31:0] ra, rb;
        logic        rs;
        int          bad;
        int          lat;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFF9};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
        vecs[6] = '{32'h1234_5678, 32'h0000_0001, 1'b1, 64'h0000_0000_1234_5678};
        vecs[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 64'h6};

        @(negedge clk);
        check("reset in_ready",  64'(rdy32),  64'd1);
        check("reset out_valid", 64'(ov32),   64'd0);
        check("reset busy",      64'(busy32), 64'd0);
        check("reset p",         p32,         64'd0);
        check("reset p16",       64'(p16),    64'd0);

        // First operation presented in the same cycle reset releases.
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp_p, $sformatf("vec%0d", i));
        end

        run_op(1, 32'h8000, 32'h0002, 1'b1, 64'hFFFF_0000, "w16 signed min");
        run_op(1, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001, "w16 unsigned max");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
            run_op(1, ra, rb, rs, model(ra, rb, rs, 16), $sformatf("w16 rnd%0d", i));
        end
        for (int i = 0; i < 60; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
            run_op(0, ra, rb, rs, model(ra, rb, rs, 32), $sformatf("w32 rnd%0d", i));
        end

        // Backpressure: hold out_ready low for 10 cycles in DONE.
        a_in = 32'd3; b_in = 32'd5; sm_in = 1'b0; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 64'(lat), 64'd32);
        bad = 0;
        repeat (10) begin
            if (!ov32 || p32 !== 64'd15 || rdy32 || !busy32) bad++;
            @(negedge clk);
        end
        check("bp stable", 64'(bad), 64'd0);
        check("bp p", p32, 64'd15);
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        check("bp in_ready", 64'(rdy32), 64'd1);
        check("bp out_valid low", 64'(ov32), 64'd0);
        check("bp p held", p32, 64'd15);

        // Reset ten cycles into RUN aborts the operation.
        a_in = 32'd7; b_in = 32'd9; sm_in = 1'b0; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid busy", 64'(busy32), 64'd1);
        reset = 1'b1;
        #1;
        check("abort out_valid", 64'(ov32),   64'd0);
        check("abort p",         p32,         64'd0);
        check("abort in_ready",  64'(rdy32),  64'd1);
        check("abort busy",      64'(busy32), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) bad++;
        end
        check("abort no output", 64'(bad), 64'd0);
        run_op(0, 32'd2, 32'd3, 1'b0, 64'd6, "after abort");

        // Back-to-back: in_valid held high across three operations.
        begin
            logic [31:0] pa[3];
            logic [31:0] pb[3];
            logic        ps[3];
            logic [63:0] pe[3];
            logic [63:0] res[3];
            int          acc_cyc[3];
            int          idx, nres, cyc;
            logic        prev_rdy;
            pa[0] = 32'd11;        pb[0] = 32'd13;        ps[0] = 1'b0; pe[0] = 64'd143;
            pa[1] = 32'h0001_0000; pb[1] = 32'h0001_0000; ps[1] = 1'b0; pe[1] = 64'h1_0000_0000;
            pa[2] = 32'hFFFF_FFFF; pb[2] = 32'hFFFF_FFFF; ps[2] = 1'b1; pe[2] = 64'd1;
            idx = 0; nres = 0; cyc = 0;
            a_in = pa[0]; b_in = pb[0]; sm_in = ps[0];
            iv32 = 1'b1; out_rdy = 1'b1;
            prev_rdy = rdy32;
            while (nres < 3 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (prev_rdy && idx < 3) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                    if (idx < 3) begin
                        a_in = pa[idx]; b_in = pb[idx]; sm_in = ps[idx];
                    end else begin
                        iv32 = 1'b0;
                    end
                end
                if (ov32) begin
                    res[nres] = p32;
                    nres++;
                end
                prev_rdy = rdy32;
            end
            @(negedge clk);
            iv32 = 1'b0; out_rdy = 1'b0;
            check("b2b accepts", 64'(idx), 64'd3);
            check("b2b results", 64'(nres), 64'd3);
            for (int i = 0; i < nres; i++) check($sformatf("b2b p%0d", i), res[i], pe[i]);
            for (int i = 0; i + 1 < idx; i++)
                check($sformatf("b2b gap%0d", i), 64'(acc_cyc[i+1] - acc_cyc[i]), 64'd34);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
